ct_mmu_iutlb_refill_ctrl: RTL and testbench
===========================================

// Module: ct_mmu_iutlb_refill_ctrl
// PURPOSE
//  Miss-handling and refill controller for the instruction uTLB. Detects misses across all
//  uTLB entries, fetches the translation from the JTLB over a req/ack + response handshake,
//  picks a victim entry and drives the per-entry update strobe and update data bus.
//  Sits directly upstream of the iutlb entry array.
// PARAMETERS
//  ENTRY_NUM  8   number of uTLB entries; power of two, >=2
//  VPN_WIDTH  27  virtual page number width (Sv39)
//  PPN_WIDTH  28  physical page number width
//  FLG_WIDTH  14  PTE flag bits kept per entry
//  PGS_WIDTH  3   one-hot page size {1G,2M,4K} = bits {2,1,0}
// PORTS
//  utlb_clk           in   1          clock
//  cpurst_b           in   1          async active-low reset
//  ifu_mmu_va_vld     in   1          instruction lookup valid this cycle
//  ifu_mmu_vpn        in   VPN_WIDTH  lookup VPN
//  utlb_entry_vld     in   ENTRY_NUM  per-entry valid from entry array
//  utlb_entry_hit     in   ENTRY_NUM  per-entry VPN match from entry array
//  regs_utlb_clr      in   1          SATP/ASID change flush
//  tlboper_utlb_clr   in   1          sfence flush
//  iutlb_jtlb_req     out  1          refill request to JTLB
//  iutlb_jtlb_vpn     out  VPN_WIDTH  refill VPN
//  jtlb_iutlb_ack     in   1          JTLB accepted request
//  jtlb_iutlb_rsp_vld in   1          refill response valid (1-cycle pulse)
//  jtlb_iutlb_pgflt   in   1          response is page fault
//  jtlb_iutlb_ppn     in   PPN_WIDTH  response PPN
//  jtlb_iutlb_flg     in   FLG_WIDTH  response flags
//  jtlb_iutlb_pgs     in   PGS_WIDTH  response page size, one-hot
//  utlb_entry_upd     out  ENTRY_NUM  one-hot entry update strobe
//  utlb_upd_vpn/ppn/flg/pgs out widths as above  update data bus
//  mmu_ifu_busy       out  1          controller not IDLE
//  mmu_ifu_refill_done out 1          1-cycle pulse: entry written
//  mmu_ifu_pgflt      out  1          1-cycle pulse: refill faulted
// BEHAVIOUR
//  - Reset: FSM=IDLE, rr_ptr=0, all outputs 0, latched vpn/ppn/flg/pgs = 0.
//  - clr = regs_utlb_clr | tlboper_utlb_clr.
//  - Miss = ifu_mmu_va_vld & ~|(utlb_entry_vld & utlb_entry_hit) & ~clr, sampled in IDLE only;
//    lookups while busy are ignored (IFU stalls on mmu_ifu_busy).
//  - FSM: IDLE -miss-> REQ (latch vpn). REQ: iutlb_jtlb_req=1, vpn stable until ack;
//    ack -> WAIT. WAIT: rsp_vld&~pgflt -> UPD (latch ppn/flg/pgs); rsp_vld&pgflt -> IDLE with
//    mmu_ifu_pgflt pulse that cycle. UPD: one cycle, utlb_entry_upd = onehot(victim),
//    mmu_ifu_refill_done=1 -> IDLE. Miss-to-upd latency: >=3 cycles (ack and rsp in same
//    cycle as entry to their states).
//  - Victim (computed in UPD): lowest-index entry with utlb_entry_vld==0; if all valid, rr_ptr,
//    and rr_ptr increments (wraps ENTRY_NUM-1 -> 0) only when used.
//  - Update data bus equals latched values in UPD, 0 otherwise.
//  - clr mid-operation: REQ & ~ack -> IDLE, req drops next cycle; REQ & ack or WAIT without
//    rsp -> DRAIN (consume one rsp_vld, no pgflt/done pulse) -> IDLE; WAIT with rsp_vld
//    -> IDLE, rsp discarded; UPD -> no upd strobe, no done pulse, rr_ptr unchanged, -> IDLE.
//    clr in IDLE has no FSM effect. rr_ptr is not reset by clr.
//  - jtlb_iutlb_rsp_vld outside WAIT/DRAIN is ignored; ack outside REQ ignored.
//  - Reset asserted in any state returns to IDLE asynchronously; all outputs drop immediately.
// STRUCTURE
//  - Package ct_mmu_iutlb_pkg: VPN/PPN/FLG/PGS width constants, enum refill_state_t
//    {IDLE,REQ,WAIT,UPD,DRAIN}, struct utlb_upd_t {vpn,ppn,flg,pgs}.
//  - One sub-module ct_mmu_iutlb_victim_sel: vld vector + rr_ptr -> one-hot victim,
//    all_vld flag (priority find-first-zero, combinational).
//  - FSM, latches and rr_ptr in this module; all flops on utlb_clk / negedge cpurst_b.
// TESTING
//  1. Miss in empty TLB, vpn=0x1234567; ack next cycle, rsp 2 cycles later ppn=0xABCDE, pgs=3'b001
//     -> upd=8'h01, upd_vpn=0x1234567, done pulse, busy low the cycle after.
//  2. All 8 valid, three successive misses -> victims entry 0,1,2; rr_ptr=3 after.
//  3. Refill with pgflt=1 -> mmu_ifu_pgflt 1 cycle, upd stays 0, rr_ptr unchanged.
//  4. tlboper_utlb_clr in WAIT, rsp arrives 4 cycles later -> DRAIN consumes it, no upd/done,
//     then new miss proceeds normally.
//  5. regs_utlb_clr in REQ before ack -> req drops next cycle, IDLE; clr coincident with UPD -> no upd.
//  6. Hit (vld&hit on entry 5) with va_vld -> no req; cpurst_b low in WAIT -> all outputs 0, IDLE.

Source files
------------

// File: rtl/ct_mmu_iutlb_pkg.sv
// ---------------------------------------------------------------------------
// ct_mmu_iutlb_pkg
//   Shared constants and types for the instruction uTLB refill path.
//   - Width constants for the VPN/PPN/flag/page-size fields of a uTLB entry.
//   - refill_state_t: state encoding of the refill controller FSM.
//   - utlb_upd_t: one entry's worth of translation data, held by the controller
//     between the JTLB response and the entry-array write.
// ---------------------------------------------------------------------------
package ct_mmu_iutlb_pkg;

  localparam int UTLB_ENTRY_NUM = 8;
  localparam int VPN_WIDTH      = 27;
  localparam int PPN_WIDTH      = 28;
  localparam int FLG_WIDTH      = 14;
  localparam int PGS_WIDTH      = 3;

  // IDLE  : waiting for a lookup miss
  // REQ   : request held towards the JTLB until it is acknowledged
  // WAIT  : request accepted, waiting for the refill response
  // UPD   : single cycle writing the victim entry
  // DRAIN : a flush cancelled an accepted request; swallow its response
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    UPD   = 3'd3,
    DRAIN = 3'd4
  } refill_state_t;

  typedef struct packed {
    logic [VPN_WIDTH-1:0] vpn;
    logic [PPN_WIDTH-1:0] ppn;
    logic [FLG_WIDTH-1:0] flg;
    logic [PGS_WIDTH-1:0] pgs;
  } utlb_upd_t;

endpackage

// File: rtl/ct_mmu_iutlb_victim_sel.sv
// ---------------------------------------------------------------------------
// ct_mmu_iutlb_victim_sel
//   Chooses which uTLB entry a refill overwrites. Purely combinational.
//   Ports:
//     entry_vld  in   ENTRY_NUM  per-entry valid bits
//     rr_ptr     in   PTR_W      round-robin pointer, used only when all valid
//     victim     out  ENTRY_NUM  one-hot victim entry
//     all_vld    out  1          every entry is valid (round-robin path taken)
// ---------------------------------------------------------------------------
module ct_mmu_iutlb_victim_sel #(
  parameter int ENTRY_NUM = 8,
  parameter int PTR_W     = $clog2(ENTRY_NUM)
) (
  input  logic [ENTRY_NUM-1:0] entry_vld,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [ENTRY_NUM-1:0] victim,
  output logic                 all_vld
);

  logic [ENTRY_NUM-1:0] free_onehot;
  logic                 found;

  // Find-first-zero: the lowest-index invalid entry wins, so free slots are
  // always filled before any live translation is evicted.
  always_comb begin
    free_onehot = '0;
    found       = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!entry_vld[i] && !found) begin
        free_onehot[i] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  assign all_vld = &entry_vld;

  // With no free slot, evict in round-robin order.
  assign victim = all_vld ? (ENTRY_NUM'(1) << rr_ptr) : free_onehot;

endmodule

// File: rtl/ct_mmu_iutlb_refill_ctrl.sv
// ---------------------------------------------------------------------------
// ct_mmu_iutlb_refill_ctrl
//   Miss-handling and refill controller for the instruction uTLB.
//   Detects a miss across all entries, fetches the translation from the JTLB
//   (req/ack, then a one-cycle response pulse), picks a victim entry and
//   drives the per-entry update strobe plus the update data bus.
//   Ports:
//     utlb_clk, cpurst_b           clock, async active-low reset
//     ifu_mmu_va_vld/vpn           instruction lookup
//     utlb_entry_vld/hit           per-entry status from the entry array
//     regs_utlb_clr                SATP/ASID change flush
//     tlboper_utlb_clr             sfence flush
//     iutlb_jtlb_req/vpn           refill request to the JTLB
//     jtlb_iutlb_ack               JTLB accepted the request
//     jtlb_iutlb_rsp_vld/pgflt/ppn/flg/pgs  refill response
//     utlb_entry_upd               one-hot entry write strobe
//     utlb_upd_vpn/ppn/flg/pgs     entry write data
//     mmu_ifu_busy                 controller not idle (IFU stalls)
//     mmu_ifu_refill_done          pulse: an entry was written
//     mmu_ifu_pgflt                pulse: refill returned a page fault
// ---------------------------------------------------------------------------
module ct_mmu_iutlb_refill_ctrl
  import ct_mmu_iutlb_pkg::*;
#(
  parameter int ENTRY_NUM = UTLB_ENTRY_NUM
) (
  input  logic                 utlb_clk,
  input  logic                 cpurst_b,
  input  logic                 ifu_mmu_va_vld,
  input  logic [VPN_WIDTH-1:0] ifu_mmu_vpn,
  input  logic [ENTRY_NUM-1:0] utlb_entry_vld,
  input  logic [ENTRY_NUM-1:0] utlb_entry_hit,
  input  logic                 regs_utlb_clr,
  input  logic                 tlboper_utlb_clr,
  output logic                 iutlb_jtlb_req,
  output logic [VPN_WIDTH-1:0] iutlb_jtlb_vpn,
  input  logic                 jtlb_iutlb_ack,
  input  logic                 jtlb_iutlb_rsp_vld,
  input  logic                 jtlb_iutlb_pgflt,
  input  logic [PPN_WIDTH-1:0] jtlb_iutlb_ppn,
  input  logic [FLG_WIDTH-1:0] jtlb_iutlb_flg,
  input  logic [PGS_WIDTH-1:0] jtlb_iutlb_pgs,
  output logic [ENTRY_NUM-1:0] utlb_entry_upd,
  output logic [VPN_WIDTH-1:0] utlb_upd_vpn,
  output logic [PPN_WIDTH-1:0] utlb_upd_ppn,
  output logic [FLG_WIDTH-1:0] utlb_upd_flg,
  output logic [PGS_WIDTH-1:0] utlb_upd_pgs,
  output logic                 mmu_ifu_busy,
  output logic                 mmu_ifu_refill_done,
  output logic                 mmu_ifu_pgflt
);

  localparam int PTR_W = $clog2(ENTRY_NUM);

  refill_state_t        state;
  logic [PTR_W-1:0]     rr_ptr;
  utlb_upd_t            upd_q;

  logic                 clr;
  logic                 lookup_hit;
  logic                 miss;
  logic                 upd_fire;
  logic                 all_vld;
  logic [ENTRY_NUM-1:0] victim;

  // Either flush source cancels whatever the controller is doing.
  assign clr        = regs_utlb_clr | tlboper_utlb_clr;
  // A hit only counts on a valid entry; a flush suppresses new misses.
  assign lookup_hit = |(utlb_entry_vld & utlb_entry_hit);
  assign miss       = ifu_mmu_va_vld & ~lookup_hit & ~clr;
  // A flush landing on the update cycle kills the write.
  assign upd_fire   = (state == UPD) & ~clr;

  ct_mmu_iutlb_victim_sel #(
    .ENTRY_NUM (ENTRY_NUM),
    .PTR_W     (PTR_W)
  ) u_victim_sel (
    .entry_vld (utlb_entry_vld),
    .rr_ptr    (rr_ptr),
    .victim    (victim),
    .all_vld   (all_vld)
  );

  // Refill FSM, translation holding register and round-robin pointer.
  // The VPN is captured on the miss and held for the whole request; the
  // response fields are captured only on a clean, fault-free response.
  // A flush after the JTLB has accepted a request must still consume the
  // matching response, hence DRAIN.
  always_ff @(posedge utlb_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state  <= IDLE;
      rr_ptr <= '0;
      upd_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state     <= REQ;
            upd_q.vpn <= ifu_mmu_vpn;
          end
        end
        REQ: begin
          if (clr) begin
            state <= jtlb_iutlb_ack ? DRAIN : IDLE;
          end else if (jtlb_iutlb_ack) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (clr) begin
            state <= jtlb_iutlb_rsp_vld ? IDLE : DRAIN;
          end else if (jtlb_iutlb_rsp_vld) begin
            if (jtlb_iutlb_pgflt) begin
              state <= IDLE;
            end else begin
              state     <= UPD;
              upd_q.ppn <= jtlb_iutlb_ppn;
              upd_q.flg <= jtlb_iutlb_flg;
              upd_q.pgs <= jtlb_iutlb_pgs;
            end
          end
        end
        UPD: begin
          state <= IDLE;
          // The pointer only advances when it actually picked the victim.
          if (upd_fire && all_vld) begin
            rr_ptr <= rr_ptr + PTR_W'(1);
          end
        end
        DRAIN: begin
          if (jtlb_iutlb_rsp_vld) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state register; the VPN and data buses are
  // forced to zero outside the states that own them.
  assign iutlb_jtlb_req      = (state == REQ);
  assign iutlb_jtlb_vpn      = (state == REQ) ? upd_q.vpn : '0;
  assign mmu_ifu_busy        = (state != IDLE);
  assign utlb_entry_upd      = upd_fire ? victim : '0;
  assign mmu_ifu_refill_done = upd_fire;
  assign mmu_ifu_pgflt       = (state == WAIT) & jtlb_iutlb_rsp_vld &
                               jtlb_iutlb_pgflt & ~clr;

  assign utlb_upd_vpn = (state == UPD) ? upd_q.vpn : '0;
  assign utlb_upd_ppn = (state == UPD) ? upd_q.ppn : '0;
  assign utlb_upd_flg = (state == UPD) ? upd_q.flg : '0;
  assign utlb_upd_pgs = (state == UPD) ? upd_q.pgs : '0;

endmodule

// File: tb/tb_ct_mmu_iutlb_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_mmu_iutlb_refill_ctrl
//   Directed self-checking bench for the iutlb refill controller. Expected
//   entry writes are queued when the refill response is driven and compared
//   by a monitor whenever the controller writes an entry.
// ---------------------------------------------------------------------------
module tb_ct_mmu_iutlb_refill_ctrl;

  logic        utlb_clk;
  logic        cpurst_b;
  logic        ifu_mmu_va_vld;
  logic [26:0] ifu_mmu_vpn;
  logic [7:0]  utlb_entry_vld;
  logic [7:0]  utlb_entry_hit;
  logic        regs_utlb_clr;
  logic        tlboper_utlb_clr;
  logic        iutlb_jtlb_req;
  logic [26:0] iutlb_jtlb_vpn;
  logic        jtlb_iutlb_ack;
  logic        jtlb_iutlb_rsp_vld;
  logic        jtlb_iutlb_pgflt;
  logic [27:0] jtlb_iutlb_ppn;
  logic [13:0] jtlb_iutlb_flg;
  logic [2:0]  jtlb_iutlb_pgs;
  logic [7:0]  utlb_entry_upd;
  logic [26:0] utlb_upd_vpn;
  logic [27:0] utlb_upd_ppn;
  logic [13:0] utlb_upd_flg;
  logic [2:0]  utlb_upd_pgs;
  logic        mmu_ifu_busy;
  logic        mmu_ifu_refill_done;
  logic        mmu_ifu_pgflt;

  typedef struct packed {
    logic [7:0]  upd;
    logic [26:0] vpn;
    logic [27:0] ppn;
    logic [13:0] flg;
    logic [2:0]  pgs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests  = 0;
  int   failed = 0;

  ct_mmu_iutlb_refill_ctrl dut (
    .utlb_clk            (utlb_clk),
    .cpurst_b            (cpurst_b),
    .ifu_mmu_va_vld      (ifu_mmu_va_vld),
    .ifu_mmu_vpn         (ifu_mmu_vpn),
    .utlb_entry_vld      (utlb_entry_vld),
    .utlb_entry_hit      (utlb_entry_hit),
    .regs_utlb_clr       (regs_utlb_clr),
    .tlboper_utlb_clr    (tlboper_utlb_clr),
    .iutlb_jtlb_req      (iutlb_jtlb_req),
    .iutlb_jtlb_vpn      (iutlb_jtlb_vpn),
    .jtlb_iutlb_ack      (jtlb_iutlb_ack),
    .jtlb_iutlb_rsp_vld  (jtlb_iutlb_rsp_vld),
    .jtlb_iutlb_pgflt    (jtlb_iutlb_pgflt),
    .jtlb_iutlb_ppn      (jtlb_iutlb_ppn),
    .jtlb_iutlb_flg      (jtlb_iutlb_flg),
    .jtlb_iutlb_pgs      (jtlb_iutlb_pgs),
    .utlb_entry_upd      (utlb_entry_upd),
    .utlb_upd_vpn        (utlb_upd_vpn),
    .utlb_upd_ppn        (utlb_upd_ppn),
    .utlb_upd_flg        (utlb_upd_flg),
    .utlb_upd_pgs        (utlb_upd_pgs),
    .mmu_ifu_busy        (mmu_ifu_busy),
    .mmu_ifu_refill_done (mmu_ifu_refill_done),
    .mmu_ifu_pgflt       (mmu_ifu_pgflt)
  );

  // 10-time-unit clock.
  initial utlb_clk = 1'b0;
  always #5 utlb_clk = ~utlb_clk;

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the IFU lookup interface.
  task automatic applyStimulus(input logic va_vld, input logic [26:0] vpn);
    ifu_mmu_va_vld = va_vld;
    ifu_mmu_vpn    = vpn;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge utlb_clk);
    #1;
  endtask

  // Full refill with immediate ack and immediate response; the expected
  // entry write is queued at the moment the response is driven.
  task automatic doRefill(input logic [26:0] vpn, input logic [27:0] ppn,
                          input logic [13:0] flg, input logic [2:0] pgs,
                          input logic [7:0] exp_upd);
    applyStimulus(1'b1, vpn);
    tick();
    applyStimulus(1'b0, '0);
    #1;
    checkOutput("req_vpn", {37'd0, iutlb_jtlb_vpn}, {37'd0, vpn});
    jtlb_iutlb_ack = 1'b1;
    tick();
    jtlb_iutlb_ack     = 1'b0;
    jtlb_iutlb_rsp_vld = 1'b1;
    jtlb_iutlb_ppn     = ppn;
    jtlb_iutlb_flg     = flg;
    jtlb_iutlb_pgs     = pgs;
    sb.push_back('{upd: exp_upd, vpn: vpn, ppn: ppn, flg: flg, pgs: pgs});
    tick();
    jtlb_iutlb_rsp_vld = 1'b0;
    #1;
    checkOutput("done_pulse", 64'(mmu_ifu_refill_done), 64'd1);
    tick();
    checkOutput("busy_after_done", 64'(mmu_ifu_busy), 64'd0);
  endtask

  // Scoreboard monitor: every entry write must match the oldest queued one.
  always @(negedge utlb_clk) begin
    if (cpurst_b === 1'b1 && (utlb_entry_upd !== 8'h00 || mmu_ifu_refill_done === 1'b1)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_upd", {56'd0, utlb_entry_upd}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("upd_strobe", {56'd0, utlb_entry_upd}, {56'd0, mon_e.upd});
        checkOutput("upd_vpn", {37'd0, utlb_upd_vpn}, {37'd0, mon_e.vpn});
        checkOutput("upd_ppn", {36'd0, utlb_upd_ppn}, {36'd0, mon_e.ppn});
        checkOutput("upd_flg", {50'd0, utlb_upd_flg}, {50'd0, mon_e.flg});
        checkOutput("upd_pgs", {61'd0, utlb_upd_pgs}, {61'd0, mon_e.pgs});
        checkOutput("upd_done", 64'(mmu_ifu_refill_done), 64'd1);
      end
    end
  end

  // Directed sequence.
  initial begin
    cpurst_b           = 1'b1;
    applyStimulus(1'b0, '0);
    utlb_entry_vld     = '0;
    utlb_entry_hit     = '0;
    regs_utlb_clr      = 1'b0;
    tlboper_utlb_clr   = 1'b0;
    jtlb_iutlb_ack     = 1'b0;
    jtlb_iutlb_rsp_vld = 1'b0;
    jtlb_iutlb_pgflt   = 1'b0;
    jtlb_iutlb_ppn     = '0;
    jtlb_iutlb_flg     = '0;
    jtlb_iutlb_pgs     = '0;
    #2 cpurst_b = 1'b0;
    #10;
    checkOutput("rst_busy", 64'(mmu_ifu_busy), 64'd0);
    checkOutput("rst_req", 64'(iutlb_jtlb_req), 64'd0);
    checkOutput("rst_upd", {56'd0, utlb_entry_upd}, 64'd0);
    checkOutput("rst_done", 64'(mmu_ifu_refill_done), 64'd0);
    @(negedge utlb_clk);
    cpurst_b = 1'b1;
    tick();

    // Stray ack/response while idle are ignored.
    jtlb_iutlb_ack     = 1'b1;
    jtlb_iutlb_rsp_vld = 1'b1;
    tick();
    jtlb_iutlb_ack     = 1'b0;
    jtlb_iutlb_rsp_vld = 1'b0;
    #1;
    checkOutput("idle_stray_busy", 64'(mmu_ifu_busy), 64'd0);

    // Test 1: empty TLB, ack next cycle, response two cycles later.
    applyStimulus(1'b1, 27'h1234567);
    tick();
    applyStimulus(1'b0, '0);
    #1;
    checkOutput("t1_req", 64'(iutlb_jtlb_req), 64'd1);
    checkOutput("t1_vpn", {37'd0, iutlb_jtlb_vpn}, 64'h1234567);
    jtlb_iutlb_ack = 1'b1;
    tick();
    jtlb_iutlb_ack = 1'b0;
    #1;
    checkOutput("t1_req_drop", 64'(iutlb_jtlb_req), 64'd0);
    tick();
    jtlb_iutlb_rsp_vld = 1'b1;
    jtlb_iutlb_ppn     = 28'hABCDE;
    jtlb_iutlb_flg     = 14'h2A5;
    jtlb_iutlb_pgs     = 3'b001;
    sb.push_back('{upd: 8'h01, vpn: 27'h1234567, ppn: 28'hABCDE, flg: 14'h2A5, pgs: 3'b001});
    tick();
    jtlb_iutlb_rsp_vld = 1'b0;
    #1;
    checkOutput("t1_done", 64'(mmu_ifu_refill_done), 64'd1);
    checkOutput("t1_upd", {56'd0, utlb_entry_upd}, 64'h01);
    tick();
    checkOutput("t1_busy_low", 64'(mmu_ifu_busy), 64'd0);
    checkOutput("t1_bus_zero", {37'd0, utlb_upd_vpn}, 64'd0);

    // Partially valid: lowest free entry is 3.
    utlb_entry_vld = 8'b0000_0111;
    doRefill(27'h0000ABC, 28'h1111111, 14'h0011, 3'b010, 8'h08);

    // Test 2: all valid, round robin starts at entry 0.
    utlb_entry_vld = 8'hFF;
    doRefill(27'h0100001, 28'h0000101, 14'h0001, 3'b001, 8'h01);
    doRefill(27'h0100002, 28'h0000102, 14'h0002, 3'b010, 8'h02);
    doRefill(27'h0100003, 28'h0000103, 14'h0003, 3'b100, 8'h04);

    // Test 3: page fault pulse, no write, pointer untouched.
    applyStimulus(1'b1, 27'h0200000);
    tick();
    applyStimulus(1'b0, '0);
    jtlb_iutlb_ack = 1'b1;
    tick();
    jtlb_iutlb_ack     = 1'b0;
    jtlb_iutlb_rsp_vld = 1'b1;
    jtlb_iutlb_pgflt   = 1'b1;
    #1;
    checkOutput("t3_pgflt", 64'(mmu_ifu_pgflt), 64'd1);
    checkOutput("t3_no_upd", {56'd0, utlb_entry_upd}, 64'd0);
    tick();
    jtlb_iutlb_rsp_vld = 1'b0;
    jtlb_iutlb_pgflt   = 1'b0;
    #1;
    checkOutput("t3_pgflt_pulse", 64'(mmu_ifu_pgflt), 64'd0);
    checkOutput("t3_idle", 64'(mmu_ifu_busy), 64'd0);
    doRefill(27'h0100004, 28'h0000104, 14'h0004, 3'b001, 8'h08);

    // Test 4: sfence flush in WAIT, response four cycles later is drained.
    applyStimulus(1'b1, 27'h0300000);
    tick();
    applyStimulus(1'b0, '0);
    jtlb_iutlb_ack = 1'b1;
    tick();
    jtlb_iutlb_ack   = 1'b0;
    tlboper_utlb_clr = 1'b1;
    tick();
    tlboper_utlb_clr = 1'b0;
    #1;
    checkOutput("t4_drain_busy", 64'(mmu_ifu_busy), 64'd1);
    checkOutput("t4_drain_req", 64'(iutlb_jtlb_req), 64'd0);
    tick();
    tick();
    tick();
    jtlb_iutlb_rsp_vld = 1'b1;
    jtlb_iutlb_pgflt   = 1'b1;
    #1;
    checkOutput("t4_no_pgflt", 64'(mmu_ifu_pgflt), 64'd0);
    checkOutput("t4_no_done", 64'(mmu_ifu_refill_done), 64'd0);
    tick();
    jtlb_iutlb_rsp_vld = 1'b0;
    jtlb_iutlb_pgflt   = 1'b0;
    #1;
    checkOutput("t4_idle", 64'(mmu_ifu_busy), 64'd0);
    doRefill(27'h0100005, 28'h0000105, 14'h0005, 3'b010, 8'h10);

    // Test 5a: SATP flush in REQ before ack; req drops the next cycle.
    applyStimulus(1'b1, 27'h0400000);
    tick();
    applyStimulus(1'b0, '0);
    regs_utlb_clr = 1'b1;
    #1;
    checkOutput("t5_req_held", 64'(iutlb_jtlb_req), 64'd1);
    tick();
    regs_utlb_clr = 1'b0;
    #1;
    checkOutput("t5_req_drop", 64'(iutlb_jtlb_req), 64'd0);
    checkOutput("t5_idle", 64'(mmu_ifu_busy), 64'd0);

    // Test 5b: flush coincident with UPD suppresses the write.
    applyStimulus(1'b1, 27'h0500000);
    tick();
    applyStimulus(1'b0, '0);
    jtlb_iutlb_ack = 1'b1;
    tick();
    jtlb_iutlb_ack     = 1'b0;
    jtlb_iutlb_rsp_vld = 1'b1;
    jtlb_iutlb_ppn     = 28'h0555555;
    tick();
    jtlb_iutlb_rsp_vld = 1'b0;
    regs_utlb_clr      = 1'b1;
    #1;
    checkOutput("t5_upd_killed", {56'd0, utlb_entry_upd}, 64'd0);
    checkOutput("t5_done_killed", 64'(mmu_ifu_refill_done), 64'd0);
    tick();
    regs_utlb_clr = 1'b0;
    #1;
    checkOutput("t5_idle_after_upd", 64'(mmu_ifu_busy), 64'd0);

    // Pointer continues from 5 and wraps 7 -> 0.
    doRefill(27'h0100006, 28'h0000106, 14'h0006, 3'b001, 8'h20);
    doRefill(27'h0100007, 28'h0000107, 14'h0007, 3'b001, 8'h40);
    doRefill(27'h0100008, 28'h0000108, 14'h0008, 3'b001, 8'h80);
    doRefill(27'h0100009, 28'h0000109, 14'h0009, 3'b001, 8'h01);
    doRefill(27'h010000A, 28'h000010A, 14'h000A, 3'b001, 8'h02);

    // Test 6a: valid hit on entry 5 raises no request.
    utlb_entry_hit = 8'h20;
    applyStimulus(1'b1, 27'h0600000);
    tick();
    applyStimulus(1'b0, '0);
    utlb_entry_hit = 8'h00;
    #1;
    checkOutput("t6_hit_no_req", 64'(iutlb_jtlb_req), 64'd0);
    checkOutput("t6_hit_idle", 64'(mmu_ifu_busy), 64'd0);

    // Test 6b: reset in WAIT drops everything and clears the pointer.
    applyStimulus(1'b1, 27'h0700000);
    tick();
    applyStimulus(1'b0, '0);
    jtlb_iutlb_ack = 1'b1;
    tick();
    jtlb_iutlb_ack = 1'b0;
    cpurst_b       = 1'b0;
    #1;
    checkOutput("t6_rst_busy", 64'(mmu_ifu_busy), 64'd0);
    checkOutput("t6_rst_req", 64'(iutlb_jtlb_req), 64'd0);
    checkOutput("t6_rst_upd", {56'd0, utlb_entry_upd}, 64'd0);
    @(negedge utlb_clk);
    cpurst_b = 1'b1;
    tick();
    doRefill(27'h010000B, 28'h000010B, 14'h000B, 3'b100, 8'h01);

    tick();
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
